// File: rtl/keccak_pkg.sv
// keccak_pkg: shared Keccak-f[1600] geometry, masking FSM states and lane helpers
package keccak_pkg;
  localparam int LANE_W = 64;
  localparam int NUM_LANES = 25;
  localparam int STATE_W = LANE_W * NUM_LANES;
  typedef enum logic [1:0] {REQ, WAIT, LOAD, OUT} state_t;
  function automatic int lane_idx(input int x, input int y);
    return x + 5 * y;
  endfunction
  function automatic logic [LANE_W-1:0] lane_sel(input logic [STATE_W-1:0] v, input int i);
    return v[i*LANE_W +: LANE_W];
  endfunction
endpackage

// File: rtl/masked_state_loader.sv
// masked_state_loader: fetches a fresh nonzero mask per state and splits serial lanes into two shares
module masked_state_loader
  import keccak_pkg::*;
#(
  parameter int RNG_LAT = 1
) (
  input  logic               clk,
  input  logic               rst,
  output logic               rng_ren,
  input  logic [STATE_W-1:0] rng_dout,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [LANE_W-1:0]  in_lane,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [STATE_W-1:0] share0,
  output logic [STATE_W-1:0] share1,
  output logic               mask_retry
);
  localparam int WW = RNG_LAT > 1 ? $clog2(RNG_LAT) : 1;
  localparam int CW = $clog2(NUM_LANES);
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WW-1:0] wait_q, wait_d;
  logic [STATE_W-1:0] mask_q, mask_d, share0_q, share0_d;
  logic [NUM_LANES-1:0] lane_we;
  logic last_wait, last_lane, retry;
  assign last_wait = wait_q == WW'(RNG_LAT - 1);
  assign last_lane = cnt_q == CW'(NUM_LANES - 1);
  assign lane_we = (in_valid && state_q == LOAD) ? NUM_LANES'(1) << cnt_q : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= REQ;
      cnt_q    <= '0;
      wait_q   <= '0;
      mask_q   <= '0;
      share0_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wait_q   <= wait_d;
      mask_q   <= mask_d;
      share0_q <= share0_d;
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wait_d  = wait_q;
    mask_d  = mask_q;
    retry   = 1'b0;
    case (state_q)
      REQ: begin
        state_d = WAIT;
        wait_d  = '0;
      end
      WAIT: begin
        if (!last_wait) wait_d = wait_q + 1'b1;
        else if (|rng_dout) begin
          mask_d  = rng_dout;
          state_d = LOAD;
        end else begin
          retry   = 1'b1;
          state_d = REQ;
        end
      end
      LOAD: begin
        if (in_valid) begin
          cnt_d   = last_lane ? '0 : cnt_q + 1'b1;
          state_d = last_lane ? OUT : LOAD;
        end
      end
      OUT: state_d = out_ready ? REQ : OUT;
      default: state_d = REQ;
    endcase
  end
  always_comb begin
    share0_d = share0_q;
    for (int i = 0; i < NUM_LANES; i++)
      if (lane_we[i]) share0_d[i*LANE_W +: LANE_W] = in_lane ^ lane_sel(mask_q, i);
  end
  // outputs are forced low while rst is held so nothing leaks before the FSM settles
  assign rng_ren    = state_q == REQ && !rst;
  assign in_ready   = state_q == LOAD && !rst;
  assign out_valid  = state_q == OUT && !rst;
  assign mask_retry = retry && !rst;
  assign share0     = share0_q;
  assign share1     = mask_q;
endmodule

// File: tb/tb_masked_state_loader.sv
// tb_masked_state_loader: directed scenarios against a one-cycle-latency PRNG stub
module tb_masked_state_loader;
  import keccak_pkg::*;
  localparam logic [STATE_W-1:0] A5 = {NUM_LANES{64'hA5A5A5A5A5A5A5A5}};
  localparam logic [STATE_W-1:0] M1 = {NUM_LANES{64'h1122334455667788}};
  localparam logic [STATE_W-1:0] M2 = {NUM_LANES{64'hDEADBEEFCAFEF00D}};
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
  logic rng_ren, in_ready, out_valid, mask_retry;
  logic [STATE_W-1:0] rng_dout = '0, share0, share1, exp_state = '0;
  logic [LANE_W-1:0] in_lane = '0;
  logic [STATE_W-1:0] mq[$];
  int checks = 0, errors = 0, cyc = 0, ren_cnt = 0, retry_cnt = 0;
  masked_state_loader #(.RNG_LAT(1)) dut (
    .clk(clk), .rst(rst), .rng_ren(rng_ren), .rng_dout(rng_dout),
    .in_valid(in_valid), .in_ready(in_ready), .in_lane(in_lane),
    .out_valid(out_valid), .out_ready(out_ready),
    .share0(share0), .share1(share1), .mask_retry(mask_retry)
  );
  always #5 clk = ~clk;
  // PRNG stub: queued masks first, then the A5 pattern
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mask_retry) retry_cnt <= retry_cnt + 1;
    if (rng_ren) begin
      ren_cnt  <= ren_cnt + 1;
      rng_dout <= (mq.size() != 0) ? mq.pop_front() : A5;
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
  task automatic feed(input int n, input int ga, input int gb, input logic [63:0] seed);
    for (int i = 0; i < n; i++) begin
      logic [63:0] v;
      int b;
      v = seed ^ 64'(i);
      exp_state[i*64 +: 64] = v;
      in_valid = 1'b1;
      in_lane  = v;
      b = 0;
      while (!in_ready && b < 100) begin
        @(negedge clk);
        b++;
      end
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL in_ready timeout lane %0d got %b exp 1", i, in_ready);
      end
      @(negedge clk);
      in_valid = 1'b0;
      if (i == ga || i == gb) repeat (3) @(negedge clk);
    end
  endtask
  task automatic accept();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (share0 !== '0) begin errors++; $display("FAIL reset share0 got %h exp 0", share0); end
    checks++;
    if (share1 !== '0) begin errors++; $display("FAIL reset share1 got %h exp 0", share1); end
    checks++;
    if ({rng_ren, in_ready, out_valid, mask_retry} !== 4'b0000) begin
      errors++;
      $display("FAIL reset ctrl got %b exp 0000", {rng_ren, in_ready, out_valid, mask_retry});
    end
    rst = 1'b0;
    #1;
    checks++;
    if (rng_ren !== 1'b1) begin errors++; $display("FAIL first_req rng_ren got %b exp 1", rng_ren); end
  endtask
  task automatic test_basic();
    int t0;
    t0 = cyc;
    feed(25, -1, -1, 64'h0);
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL basic out_valid got %b exp 1", out_valid); end
    // REQ is cycle 0 of 28, so out_valid belongs to cycle 27
    checks++;
    if (cyc - t0 != 27) begin errors++; $display("FAIL basic latency got %0d exp 27", cyc - t0); end
    checks++;
    if (share1 !== A5) begin errors++; $display("FAIL basic share1 got %h exp A5..", share1); end
    for (int i = 0; i < 25; i++) begin
      checks++;
      if (share0[i*64 +: 64] !== (64'(i) ^ 64'hA5A5A5A5A5A5A5A5))
        begin errors++; $display("FAIL basic share0 lane %0d got %h", i, share0[i*64 +: 64]); end
    end
    accept();
    checks++;
    if (rng_ren !== 1'b1) begin errors++; $display("FAIL basic next_req got %b exp 1", rng_ren); end
  endtask
  task automatic test_retry();
    int r0, n0, b;
    r0 = retry_cnt;
    n0 = ren_cnt;
    mq.push_back('0);
    mq.push_back(STATE_W'(1));
    b = 0;
    while (!in_ready && b < 50) begin
      @(negedge clk);
      b++;
    end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL retry in_ready got %b exp 1", in_ready); end
    checks++;
    if (retry_cnt - r0 != 1) begin errors++; $display("FAIL retry pulses got %0d exp 1", retry_cnt - r0); end
    checks++;
    if (ren_cnt - n0 != 2) begin errors++; $display("FAIL retry rng_ren got %0d exp 2", ren_cnt - n0); end
    checks++;
    if (share1 !== STATE_W'(1)) begin errors++; $display("FAIL retry share1 got %h exp 1", share1); end
    feed(25, -1, -1, 64'hFEDCBA9876543210);
    checks++;
    if (out_valid !== 1'b1 || share0 !== (exp_state ^ STATE_W'(1)))
      begin errors++; $display("FAIL retry share0 got %h ov %b", share0, out_valid); end
    accept();
    checks++;
    if (rng_ren !== 1'b1) begin errors++; $display("FAIL retry next_req got %b exp 1", rng_ren); end
  endtask
  task automatic test_stall();
    feed(25, -1, -1, 64'h0F1E2D3C4B5A6978);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checks++;
      if ({out_valid, rng_ren} !== 2'b10 || share0 !== (exp_state ^ A5) || share1 !== A5)
        begin errors++; $display("FAIL stall cycle %0d ov/ren got %b exp 10", k, {out_valid, rng_ren}); end
    end
    accept();
    checks++;
    if (rng_ren !== 1'b1) begin errors++; $display("FAIL stall next_req got %b exp 1", rng_ren); end
  endtask
  task automatic test_gaps();
    int t0;
    t0 = cyc;
    feed(25, 4, 17, 64'h8000000000000001);
    checks++;
    if (out_valid !== 1'b1 || cyc - t0 != 33)
      begin errors++; $display("FAIL gaps latency got %0d ov %b exp 33", cyc - t0, out_valid); end
    checks++;
    if (share0 !== (exp_state ^ A5) || share1 !== A5)
      begin errors++; $display("FAIL gaps share0 got %h", share0); end
    accept();
    checks++;
    if (rng_ren !== 1'b1) begin errors++; $display("FAIL gaps next_req got %b exp 1", rng_ren); end
  endtask
  task automatic test_abort();
    feed(13, -1, -1, 64'h5555AAAA5555AAAA);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (share0 !== '0 || share1 !== '0) begin errors++; $display("FAIL abort shares got %h", share0); end
    checks++;
    if ({in_ready, out_valid} !== 2'b00)
      begin errors++; $display("FAIL abort ctrl got %b exp 00", {in_ready, out_valid}); end
    rst = 1'b0;
    #1;
    checks++;
    if (rng_ren !== 1'b1) begin errors++; $display("FAIL abort req got %b exp 1", rng_ren); end
    feed(25, -1, -1, 64'h0123456789ABCDEF);
    checks++;
    if (out_valid !== 1'b1 || share0 !== (exp_state ^ A5) || share1 !== A5)
      begin errors++; $display("FAIL abort refill share0 got %h ov %b", share0, out_valid); end
    accept();
  endtask
  task automatic test_back_to_back();
    mq.push_back(M1);
    mq.push_back(M2);
    feed(25, -1, -1, 64'hCAFEBABE00000000);
    checks++;
    if (share1 !== M1) begin errors++; $display("FAIL b2b first share1 got %h", share1); end
    checks++;
    if ((share0 ^ share1) !== exp_state) begin errors++; $display("FAIL b2b first unmask got %h", share0 ^ share1); end
    accept();
    feed(25, -1, -1, 64'h00000000BEEFF00D);
    checks++;
    if (share1 !== M2) begin errors++; $display("FAIL b2b second share1 got %h", share1); end
    checks++;
    if ((share0 ^ share1) !== exp_state) begin errors++; $display("FAIL b2b second unmask got %h", share0 ^ share1); end
    accept();
  endtask
  initial begin
    test_reset();
    test_basic();
    test_retry();
    test_stall();
    test_gaps();
    test_abort();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
